// File: rtl/cc_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cc_update_ctrl_if
// Description : Bundles the Execute-stage, status and CC-register signals
//               exchanged between the pipeline (master) and the condition-code
//               update controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cc_update_ctrl_if #(
    parameter int STAT_W = 3,
    parameter int CNT_W  = 16
);
    logic [3:0]        e_icode;
    logic [3:0]        e_ifun;
    logic              e_bubble;
    logic              e_stall;
    logic [2:0]        alu_flags;
    logic [2:0]        cc_q;
    logic [STAT_W-1:0] m_stat;
    logic [STAT_W-1:0] w_stat;

    logic              cc_set;
    logic [2:0]        cc_in;
    logic              cc_clr;
    logic              e_cnd;
    logic              frozen;
    logic              halted;
    logic [CNT_W-1:0]  upd_cnt;
    logic [2:0]        snap_flags;
    logic              snap_valid;

    // Pipeline side: drives stage state, observes controller decisions
    modport master (
        output e_icode, e_ifun, e_bubble, e_stall, alu_flags, cc_q, m_stat, w_stat,
        input  cc_set, cc_in, cc_clr, e_cnd, frozen, halted, upd_cnt, snap_flags, snap_valid
    );

    // Controller side
    modport slave (
        input  e_icode, e_ifun, e_bubble, e_stall, alu_flags, cc_q, m_stat, w_stat,
        output cc_set, cc_in, cc_clr, e_cnd, frozen, halted, upd_cnt, snap_flags, snap_valid
    );
endinterface
`default_nettype wire

// File: rtl/cc_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cc_update_ctrl
// Description : Y86-64 condition-code sequencing controller. Gates CC loads to
//               unstalled, unbubbled OPq in Execute with no exception in M/W,
//               evaluates jXX/cmovXX conditions, tracks RUN/HALT/FREEZE status
//               and counts committed CC updates (saturating).
//               Optional macro CC_SNAPSHOT_EN adds a CC snapshot taken when
//               the processor leaves RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_update_ctrl #(
    parameter int STAT_W = 3,
    parameter int CNT_W  = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    cc_update_ctrl_if.slave bus
);

    localparam logic [STAT_W-1:0] c_stat_aok = STAT_W'(1);
    localparam logic [STAT_W-1:0] c_stat_hlt = STAT_W'(2);
    localparam logic [STAT_W-1:0] c_stat_adr = STAT_W'(3);
    localparam logic [STAT_W-1:0] c_stat_ins = STAT_W'(4);
    localparam logic [3:0]        c_iopq     = 4'd6;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_frozen;
    logic             r_halted;
    logic [CNT_W-1:0] r_upd_cnt;

    logic w_all_aok;
    logic w_any_hlt;
    logic w_any_exc;
    logic w_cc_set;
    logic w_lt;
    logic w_zf;
    logic w_cnd;

    // Status decode; unknown codes are neither AOK nor a transition trigger
    always_comb begin
        w_all_aok = (bus.m_stat == c_stat_aok) && (bus.w_stat == c_stat_aok);
        w_any_hlt = (bus.m_stat == c_stat_hlt) || (bus.w_stat == c_stat_hlt);
        w_any_exc = (bus.m_stat == c_stat_adr) || (bus.m_stat == c_stat_ins) ||
                    (bus.w_stat == c_stat_adr) || (bus.w_stat == c_stat_ins);
    end

    // CC load enable: blocked in the same cycle an exception shows up in M/W
    always_comb begin
        w_cc_set = reset && (r_state == ST_RUN) && (bus.e_icode == c_iopq) &&
                   !bus.e_bubble && !bus.e_stall && w_all_aok;
    end

    // Branch/cmov condition from the current CC value
    always_comb begin
        w_lt  = bus.cc_q[2] ^ bus.cc_q[1];
        w_zf  = bus.cc_q[0];
        w_cnd = 1'b0;
        case (bus.e_ifun)
            4'd0:    w_cnd = 1'b1;
            4'd1:    w_cnd = w_lt | w_zf;
            4'd2:    w_cnd = w_lt;
            4'd3:    w_cnd = w_zf;
            4'd4:    w_cnd = ~w_zf;
            4'd5:    w_cnd = ~w_lt;
            4'd6:    w_cnd = ~w_lt & ~w_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    // Status FSM; exceptions take priority over HLT, HALT/FREEZE are absorbing
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_frozen <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_any_exc) begin
                        r_state  <= ST_FREEZE;
                        r_frozen <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (w_any_hlt) begin
                        r_state  <= ST_HALT;
                        r_frozen <= 1'b1;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT, ST_FREEZE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state  <= ST_FREEZE;
                    r_frozen <= 1'b1;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of committed CC updates
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upd_cnt <= '0;
        end else if (w_cc_set && (r_upd_cnt != {CNT_W{1'b1}})) begin
            r_upd_cnt <= r_upd_cnt + CNT_W'(1);
        end
    end

`ifdef CC_SNAPSHOT_EN
    logic [2:0] r_snap_flags;
    logic       r_snap_valid;
    logic       w_leave_run;

    assign w_leave_run = (r_state == ST_RUN) && (w_any_exc || w_any_hlt);

    // Capture the architectural CC value at the moment execution stops
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snap_flags <= 3'b000;
            r_snap_valid <= 1'b0;
        end else if (w_leave_run) begin
            r_snap_flags <= bus.cc_q;
            r_snap_valid <= 1'b1;
        end
    end

    // Leaving RUN needs a non-AOK stat, which already forces cc_set low
    a_no_set_on_leave: assert property (@(posedge clk) disable iff (!reset)
        w_leave_run |-> !w_cc_set);

    assign bus.snap_flags = r_snap_flags;
    assign bus.snap_valid = r_snap_valid;
`else
    assign bus.snap_flags = 3'b000;
    assign bus.snap_valid = 1'b0;
`endif

    assign bus.cc_set  = w_cc_set;
    assign bus.cc_in   = bus.alu_flags;
    assign bus.cc_clr  = !reset;
    assign bus.e_cnd   = w_cnd;
    assign bus.frozen  = r_frozen;
    assign bus.halted  = r_halted;
    assign bus.upd_cnt = r_upd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cc_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_update_ctrl
// Description : Scoreboard bench for cc_update_ctrl. A 16-bit-counter DUT and
//               a 4-bit-counter DUT share stimulus; expectations are queued
//               per cycle and checked by an independent monitor.
//               Snapshot expectations follow CC_SNAPSHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_update_ctrl;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    logic clk;
    logic rst_n;

    cc_update_ctrl_if #(.STAT_W(3), .CNT_W(16)) bus0 ();
    cc_update_ctrl_if #(.STAT_W(3), .CNT_W(4))  bus1 ();

    cc_update_ctrl #(.STAT_W(3), .CNT_W(16)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    cc_update_ctrl #(.STAT_W(3), .CNT_W(4))  dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    assign bus1.e_icode   = bus0.e_icode;
    assign bus1.e_ifun    = bus0.e_ifun;
    assign bus1.e_bubble  = bus0.e_bubble;
    assign bus1.e_stall   = bus0.e_stall;
    assign bus1.alu_flags = bus0.alu_flags;
    assign bus1.cc_q      = bus0.cc_q;
    assign bus1.m_stat    = bus0.m_stat;
    assign bus1.w_stat    = bus0.w_stat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    set, clr, cin, cnd, frz, hlt, cnt, cnt4, snf, snv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt16 = 0;
    int   m_cnt4  = 0;
    bit   cnt_known = 0;

    task automatic chk(string nm, string f, int act, int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL %s.%s got %0d expected %0d", nm, f, act, exp);
            end
        end
    endtask

    // Drive one cycle of stimulus and queue its hand-computed expectation
    task automatic step(string nm, logic rn, logic [3:0] ic, logic [3:0] fn,
                        logic bub, logic stl, logic [2:0] alu, logic [2:0] ccq,
                        logic [2:0] ms, logic [2:0] ws,
                        int xs, int xc, int xf, int xh, int xsnf, int xsnv);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rn;
        bus0.e_icode   = ic;
        bus0.e_ifun    = fn;
        bus0.e_bubble  = bub;
        bus0.e_stall   = stl;
        bus0.alu_flags = alu;
        bus0.cc_q      = ccq;
        bus0.m_stat    = ms;
        bus0.w_stat    = ws;
`ifndef CC_SNAPSHOT_EN
        if (xsnf >= 0) xsnf = 0;
        if (xsnv >= 0) xsnv = 0;
`endif
        e.nm   = nm;
        e.set  = xs;
        e.clr  = rn ? 0 : 1;
        e.cin  = int'(alu);
        e.cnd  = xc;
        e.frz  = xf;
        e.hlt  = xh;
        e.cnt  = cnt_known ? m_cnt16 : -1;
        e.cnt4 = cnt_known ? m_cnt4  : -1;
        e.snf  = xsnf;
        e.snv  = xsnv;
        q.push_back(e);
        if (!rn) begin
            m_cnt16   = 0;
            m_cnt4    = 0;
            cnt_known = 1;
        end else if (xs == 1) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15)     m_cnt4++;
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "cc_set",     int'(bus0.cc_set),     e.set);
                chk(e.nm, "cc_clr",     int'(bus0.cc_clr),     e.clr);
                chk(e.nm, "cc_in",      int'(bus0.cc_in),      e.cin);
                chk(e.nm, "e_cnd",      int'(bus0.e_cnd),      e.cnd);
                chk(e.nm, "frozen",     int'(bus0.frozen),     e.frz);
                chk(e.nm, "halted",     int'(bus0.halted),     e.hlt);
                chk(e.nm, "upd_cnt",    int'(bus0.upd_cnt),    e.cnt);
                chk(e.nm, "upd_cnt4",   int'(bus1.upd_cnt),    e.cnt4);
                chk(e.nm, "snap_flags", int'(bus0.snap_flags), e.snf);
                chk(e.nm, "snap_valid", int'(bus0.snap_valid), e.snv);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus0.e_icode = 4'd0; bus0.e_ifun = 4'd0; bus0.e_bubble = 1'b0; bus0.e_stall = 1'b0;
        bus0.alu_flags = 3'b000; bus0.cc_q = 3'b000; bus0.m_stat = AOK; bus0.w_stat = AOK;

        //   name        rn ic    fn    bub   stl   alu     ccq     m    w    set cnd frz hlt snf snv
        step("rst0",     0, 4'd6, 4'd0, 1'b0, 1'b0, 3'b001, 3'b000, AOK, AOK, 0, 1, -1, -1, -1, -1);
        step("rst1",     0, 4'd6, 4'd0, 1'b0, 1'b0, 3'b001, 3'b000, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("opq",      1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b001, 3'b000, AOK, AOK, 1, 1,  0,  0,  0,  0);
        step("stall",    1, 4'd6, 4'd0, 1'b0, 1'b1, 3'b010, 3'b001, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("bubble",   1, 4'd6, 4'd0, 1'b1, 1'b0, 3'b010, 3'b001, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("jxx",      1, 4'd7, 4'd0, 1'b0, 1'b0, 3'b010, 3'b001, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("unk_stat", 1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b010, 3'b001, 3'd0, AOK, 0, 1,  0,  0,  0,  0);
        // cc_q=010: lt=1, ZF=0
        step("cnd0",     1, 4'd2, 4'd0, 1'b0, 1'b0, 3'b000, 3'b010, AOK, 3'd5, 0, 1,  0,  0,  0,  0);
        step("cnd1",     1, 4'd2, 4'd1, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("cnd2",     1, 4'd2, 4'd2, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("cnd3",     1, 4'd2, 4'd3, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 0,  0,  0,  0,  0);
        step("cnd4",     1, 4'd2, 4'd4, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("cnd5",     1, 4'd2, 4'd5, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 0,  0,  0,  0,  0);
        step("cnd6",     1, 4'd2, 4'd6, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 0,  0,  0,  0,  0);
        step("cnd7",     1, 4'd2, 4'd7, 1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 0,  0,  0,  0,  0);
        step("cnd15",    1, 4'd2, 4'd15,1'b0, 1'b0, 3'b000, 3'b010, AOK, AOK, 0, 0,  0,  0,  0,  0);
        step("cnd_e_z",  1, 4'd7, 4'd3, 1'b0, 1'b0, 3'b000, 3'b001, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("cnd_l_of", 1, 4'd7, 4'd2, 1'b0, 1'b0, 3'b000, 3'b101, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("cnd_g_of", 1, 4'd7, 4'd6, 1'b0, 1'b0, 3'b000, 3'b101, AOK, AOK, 0, 0,  0,  0,  0,  0);
        // Exception in Memory blocks the same-cycle update, then freezes
        step("adr",      1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b011, 3'b000, ADR, AOK, 0, 1,  0,  0,  0,  0);
        step("frz_opq",  1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b011, 3'b000, AOK, AOK, 0, 1,  1,  0,  0,  1);
        step("frz_opq2", 1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b011, 3'b000, AOK, AOK, 0, 1,  1,  0,  0,  1);
        step("rst2",     0, 4'd6, 4'd0, 1'b0, 1'b0, 3'b011, 3'b000, AOK, AOK, 0, 1,  1,  0,  0,  1);
        step("run2",     1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  0,  0,  0,  0);
        // HLT and INS together: FREEZE wins, snapshot takes cc_q=101
        step("hlt_ins",  1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b101, INS, HLT, 0, 1,  0,  0,  0,  0);
        step("frz_snap", 1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  1,  0,  5,  1);
        step("rst3",     0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  1,  0,  5,  1);
        step("run3",     1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b110, 3'b000, AOK, AOK, 1, 1,  0,  0,  0,  0);
        // Plain HLT goes to HALT, which then ignores a later exception
        step("hlt",      1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b011, AOK, HLT, 0, 1,  0,  0,  0,  0);
        step("halt",     1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, ADR, AOK, 0, 1,  1,  1,  3,  1);
        step("halt_abs", 1, 4'd6, 4'd0, 1'b0, 1'b0, 3'b001, 3'b000, AOK, AOK, 0, 1,  1,  1,  3,  1);
        step("rst4",     0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  1,  1,  3,  1);
        // 20 back-to-back updates: 4-bit counter pins at 15, 16-bit reaches 20
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 1, 4'd6, 4'd0, 1'b0, 1'b0, 3'(i), 3'b000, AOK, AOK, 1, 1, 0, 0, 0, 0);
        step("sat_end",  1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  0,  0,  0,  0);
        step("sat_hold", 1, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000, 3'b000, AOK, AOK, 0, 1,  0,  0,  0,  0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cc_update_ctrl.md
Name: cc_update_ctrl

Overview:
- Sequencing controller for the 3-bit condition-code register in the Y86-64 pipeline.
- Decides each cycle whether the CC register loads the ALU flags. Only an unstalled, unbubbled OPq in Execute loads them, and only while no exception is in flight in Memory or Writeback.
- Evaluates the jXX/cmovXX condition from the current CC value.
- Tracks processor status in a small FSM that freezes CC updates after HLT or an exception, and counts committed CC updates.

Parameters:
- STAT_W, 3: width of the pipeline status codes. Codes are AOK=1, HLT=2, ADR=3, INS=4.
- CNT_W, 16: width of the saturating CC-update counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- e_icode, input, 4: icode of the instruction in Execute. IOPQ=6, IJXX=7, IRRMOVQ/cmov=2.
- e_ifun, input, 4: ifun of the instruction in Execute.
- e_bubble, input, 1: Execute holds a bubble.
- e_stall, input, 1: Execute is stalled this cycle.
- alu_flags, input, 3: flags from the ALU this cycle, {OF,SF,ZF}.
- cc_q, input, 3: current CC register output, {OF,SF,ZF}.
- m_stat, input, STAT_W: status of the instruction in Memory.
- w_stat, input, STAT_W: status of the instruction in Writeback.
- cc_set, output, 1: load enable to the CC register.
- cc_in, output, 3: data to the CC register. Equals alu_flags.
- cc_clr, output, 1: synchronous clear request to the CC register.
- e_cnd, output, 1: condition result for e_ifun evaluated on cc_q.
- frozen, output, 1: FSM is in FREEZE or HALT.
- halted, output, 1: FSM is in HALT.
- upd_cnt, output, CNT_W: number of committed CC updates, saturating.
- snap_flags, output, 3: CC value captured at freeze (see Optional Feature).
- snap_valid, output, 1: snap_flags holds a capture.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FSM goes to RUN.
  - upd_cnt=0, snap_flags=0, snap_valid=0.
  - cc_clr=1 combinationally while reset=0, so the CC register clears in the same edge. cc_clr=0 otherwise.
  - cc_set=0 while reset=0.
- FSM states: RUN, HALT, FREEZE. Encoding is free.
  - RUN to HALT: m_stat==HLT or w_stat==HLT.
  - RUN to FREEZE: m_stat or w_stat is ADR or INS.
  - Simultaneous HLT and ADR/INS: FREEZE wins.
  - HALT and FREEZE are absorbing. Only reset leaves them.
- Outputs: frozen=(state!=RUN), halted=(state==HALT). Both are registered.
- cc_set is combinational. It is 1 only when all of the following hold:
  - reset=1 and state==RUN;
  - e_icode==6, e_bubble=0, e_stall=0;
  - m_stat==AOK and w_stat==AOK.
  - The m_stat/w_stat check is also combinational, so an exception arriving in M/W blocks the update in the same cycle, before the FSM transitions.
- cc_in=alu_flags at all times. Latency: flags are visible on cc_q the cycle after cc_set.
- e_cnd is combinational on cc_q and e_ifun, with SF^OF written as "lt":
  - ifun 0 (always): 1.
  - ifun 1 (le): lt|ZF.
  - ifun 2 (l): lt.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~lt.
  - ifun 6 (g): ~lt & ~ZF.
  - ifun 7 to 15: 0.
  - e_cnd is independent of e_icode and of FSM state.
- upd_cnt increments by 1 on every edge where cc_set=1. It saturates at all-ones and does not wrap.
- Reset mid-operation: all state returns to reset values at that edge. Any pending cc_set that cycle is suppressed.
- Unknown stat codes (0, 5 to 7) are treated as not-AOK for cc_set. They do not cause an FSM transition.

Optional Feature:
- Macro: CC_SNAPSHOT_EN.
- Defined: on the edge where the FSM leaves RUN, snap_flags<=cc_q and snap_valid<=1. Both hold until reset. If cc_set=1 on the same edge is impossible by construction; that case is asserted in simulation.
- Undefined: no snapshot register. snap_flags=0 and snap_valid=0 constant. Ports remain present.

Test Plan:
- Reset then unstalled OPq (e_icode=6, alu_flags=3'b001, stats AOK) -> cc_set=1 that cycle; cc_clr=1 only during reset; upd_cnt=1 next cycle.
- OPq with e_stall=1, then with e_bubble=1, then e_icode=7 -> cc_set=0 in all three; upd_cnt unchanged.
- cc_q=3'b010 (SF=1, OF=0), sweep e_ifun 0 to 7 -> e_cnd = 1,1,1,0,1,0,0,0.
- OPq in E with m_stat=ADR -> cc_set=0 same cycle; next cycle frozen=1, halted=0; later OPq with AOK stats still gives cc_set=0.
- w_stat=HLT and m_stat=INS in the same cycle -> FREEZE (frozen=1, halted=0). With CC_SNAPSHOT_EN and cc_q=3'b101 -> snap_flags=3'b101, snap_valid=1. reset=0 for one edge clears everything, and RUN resumes.
- CNT_W=4, 20 consecutive valid OPqs -> upd_cnt saturates at 15 and stays there.
